vscale_hpm_counter_bank: RTL and testbench

Parametrised bank of hardware performance-monitor counters for the vscale pipeline.
- Provides NUM_CTRS event counters of CTR_WIDTH bits, each with an event selector, an inhibit bit and a sticky overflow flag with an interrupt.
- Is accessed through the core CSR command port and through an HTIF host request/response port.
- Sits beside the CSR file; the CSR file ORs this block's `rdata` and `hit` into its own read path.

---
 rtl/vscale_hpm_counter_bank_pkg.sv | 23 ++
 rtl/vscale_hpm_counter.sv | 80 ++++++++
 rtl/vscale_hpm_counter_bank.sv | 178 +++++++++++++++++
 tb/tb_vscale_hpm_counter_bank.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_hpm_counter_bank_pkg.sv
// Shared constants for the vscale HPM counter bank.
// CSR command encodings and default CSR addresses.
package vscale_hpm_counter_bank_pkg;

    localparam logic [2:0] CSR_IDLE  = 3'd0;
    localparam logic [2:0] CSR_READ  = 3'd4;
    localparam logic [2:0] CSR_WRITE = 3'd5;
    localparam logic [2:0] CSR_SET   = 3'd6;
    localparam logic [2:0] CSR_CLEAR = 3'd7;

    localparam logic [11:0] CSR_ADDR_MHPMCOUNTER_BASE  = 12'hB03;
    localparam logic [11:0] CSR_ADDR_MHPMCOUNTERH_BASE = 12'hB83;
    localparam logic [11:0] CSR_ADDR_MHPMEVENT_BASE    = 12'h323;
    localparam logic [11:0] CSR_ADDR_MHPMINHIBIT       = 12'h320;
    localparam logic [11:0] CSR_ADDR_MHPMOVF           = 12'h7C0;
    localparam logic [11:0] CSR_ADDR_MHPMOVF_IE        = 12'h7C1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } htif_state_e;

endpackage

// File: rtl/vscale_hpm_counter.sv
// One HPM counter: event mux, inhibit gating, wrap detection.
// Optional high-half shadow under VSCALE_HPM_SNAPSHOT_EN.
module vscale_hpm_counter #(
    parameter int XLEN       = 32,
    parameter int CTR_WIDTH  = 64,
    parameter int NUM_EVENTS = 8,
    parameter int ESW        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic [ESW-1:0]        evt_sel,
    input  logic                  inhibit,
    input  logic                  we_lo,
    input  logic                  we_hi,
    input  logic                  snap,
    input  logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       lo_rd,
    output logic [XLEN-1:0]       hi_rd,
    output logic                  wrap
);

    localparam bit HAS_HI = CTR_WIDTH > XLEN;

    logic [CTR_WIDTH-1:0] cnt;
    logic [CTR_WIDTH-1:0] wr_val;
    logic                 ev;
    logic                 inc;
    logic                 unused_ok;

    // Out-of-range selectors match no event and never count.
    always_comb begin
        ev = 1'b0;
        for (int j = 0; j < NUM_EVENTS; j++) begin
            if (evt_sel == ESW'(j)) ev = events[j];
        end
    end

    assign inc  = ev & ~inhibit & ~we_lo & ~we_hi;
    assign wrap = inc & (&cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (we_lo | we_hi) begin
            cnt <= wr_val;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    generate
        if (HAS_HI) begin : g_hi
            localparam int HW = CTR_WIDTH - XLEN;
            assign wr_val = we_hi ? {wdata[HW-1:0], cnt[XLEN-1:0]}
                                  : {cnt[CTR_WIDTH-1:XLEN], wdata};
            assign lo_rd  = cnt[XLEN-1:0];
`ifdef VSCALE_HPM_SNAPSHOT_EN
            logic [HW-1:0] shadow;
            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow <= '0;
                end else if (snap) begin
                    shadow <= cnt[CTR_WIDTH-1:XLEN];
                end
            end
            assign hi_rd = XLEN'(shadow);
`else
            assign hi_rd = XLEN'(cnt[CTR_WIDTH-1:XLEN]);
`endif
        end else begin : g_lo_only
            assign wr_val = wdata[CTR_WIDTH-1:0];
            assign lo_rd  = XLEN'(cnt);
            assign hi_rd  = '0;
        end
    endgenerate

    assign unused_ok = ^{wdata, snap, we_hi};

endmodule

// File: rtl/vscale_hpm_counter_bank.sv
// Bank of HPM counters with CSR decode, masks and HTIF host port.
// Optional coherent high-half reads: VSCALE_HPM_SNAPSHOT_EN.
module vscale_hpm_counter_bank
    import vscale_hpm_counter_bank_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter int          NUM_CTRS     = 4,
    parameter int          CTR_WIDTH    = 64,
    parameter int          NUM_EVENTS   = 8,
    parameter logic [11:0] LO_BASE      = CSR_ADDR_MHPMCOUNTER_BASE,
    parameter logic [11:0] HI_BASE      = CSR_ADDR_MHPMCOUNTERH_BASE,
    parameter logic [11:0] EVT_BASE     = CSR_ADDR_MHPMEVENT_BASE,
    parameter logic [11:0] INHIBIT_ADDR = CSR_ADDR_MHPMINHIBIT,
    parameter logic [11:0] OVF_ADDR     = CSR_ADDR_MHPMOVF,
    parameter logic [11:0] OVF_IE_ADDR  = CSR_ADDR_MHPMOVF_IE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [11:0]           addr,
    input  logic [2:0]            cmd,
    input  logic [1:0]            prv,
    input  logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       rdata,
    output logic                  hit,
    output logic                  illegal_access,
    input  logic [NUM_EVENTS-1:0] events,
    output logic                  ovf_irq,
    input  logic                  htif_pcr_req_valid,
    output logic                  htif_pcr_req_ready,
    input  logic                  htif_pcr_req_rw,
    input  logic [11:0]           htif_pcr_req_addr,
    input  logic [63:0]           htif_pcr_req_data,
    output logic                  htif_pcr_resp_valid,
    input  logic                  htif_pcr_resp_ready,
    output logic [63:0]           htif_pcr_resp_data
);

    localparam int ESW    = $clog2(NUM_EVENTS) + 1;
    localparam bit HAS_HI = CTR_WIDTH > XLEN;

    logic [ESW-1:0]      evt_sel [NUM_CTRS];
    logic [XLEN-1:0]     lo_rd   [NUM_CTRS];
    logic [XLEN-1:0]     hi_rd   [NUM_CTRS];
    logic [NUM_CTRS-1:0] inhibit, ovf, ovf_ie, wrap;
    logic [NUM_CTRS-1:0] we_lo, we_hi, snap;

    htif_state_e     state, state_nxt;
    logic [XLEN:0]   host_rd;
    logic [XLEN-1:0] core_val, wval;
    logic [11:0]     waddr;
    logic            write, core_wen, core_rd, fire, wen;
    logic            unused_ok;

    // Returns {hit, zero-extended data} for one address.
    function automatic logic [XLEN:0] csr_read(input logic [11:0] a);
        logic [XLEN:0] r;
        r = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (a == LO_BASE + 12'(i)) r = {1'b1, lo_rd[i]};
            if (HAS_HI && a == HI_BASE + 12'(i)) r = {1'b1, hi_rd[i]};
            if (a == EVT_BASE + 12'(i)) r = {1'b1, XLEN'(evt_sel[i])};
        end
        if (a == INHIBIT_ADDR) r = {1'b1, XLEN'(inhibit)};
        if (a == OVF_ADDR)     r = {1'b1, XLEN'(ovf)};
        if (a == OVF_IE_ADDR)  r = {1'b1, XLEN'(ovf_ie)};
        return r;
    endfunction

    assign {hit, rdata} = csr_read(addr);
    assign host_rd      = csr_read(htif_pcr_req_addr);

    assign write          = cmd[2] & (cmd[1] | cmd[0]);
    assign illegal_access = cmd[2] & (~hit | (addr[9:8] > prv)
                          | (write & (addr[11:10] == 2'b11)));
    assign core_wen       = write & hit & ~illegal_access;
    assign core_rd        = cmd[2] & (cmd != CSR_WRITE) & ~illegal_access;

    always_comb begin
        core_val = wdata;
        case (cmd)
            CSR_SET:   core_val = rdata | wdata;
            CSR_CLEAR: core_val = rdata & ~wdata;
            default:   core_val = wdata;
        endcase
    end

    // Host is stalled whenever the core writes, so one write port suffices.
    assign fire  = htif_pcr_req_valid & htif_pcr_req_ready;
    assign wen   = core_wen | (fire & htif_pcr_req_rw);
    assign waddr = core_wen ? addr : htif_pcr_req_addr;
    assign wval  = core_wen ? core_val : htif_pcr_req_data[XLEN-1:0];

    always_comb begin
        for (int i = 0; i < NUM_CTRS; i++) begin
            we_lo[i] = wen & (waddr == LO_BASE + 12'(i));
            we_hi[i] = wen & HAS_HI & (waddr == HI_BASE + 12'(i));
            snap[i]  = (core_rd & (addr == LO_BASE + 12'(i)))
                     | (fire & ~htif_pcr_req_rw
                        & (htif_pcr_req_addr == LO_BASE + 12'(i)));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CTRS; g++) begin : g_ctr
            vscale_hpm_counter #(
                .XLEN       (XLEN),
                .CTR_WIDTH  (CTR_WIDTH),
                .NUM_EVENTS (NUM_EVENTS),
                .ESW        (ESW)
            ) u_ctr (
                .clk     (clk),
                .reset   (reset),
                .events  (events),
                .evt_sel (evt_sel[g]),
                .inhibit (inhibit[g]),
                .we_lo   (we_lo[g]),
                .we_hi   (we_hi[g]),
                .snap    (snap[g]),
                .wdata   (wval),
                .lo_rd   (lo_rd[g]),
                .hi_rd   (hi_rd[g]),
                .wrap    (wrap[g])
            );
        end
    endgenerate

    // A wrap in the same cycle as a software clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            inhibit <= '1;
            ovf     <= '0;
            ovf_ie  <= '0;
            for (int i = 0; i < NUM_CTRS; i++) evt_sel[i] <= '0;
        end else begin
            if (wen && waddr == INHIBIT_ADDR) inhibit <= wval[NUM_CTRS-1:0];
            if (wen && waddr == OVF_IE_ADDR)  ovf_ie  <= wval[NUM_CTRS-1:0];
            ovf <= ((wen && waddr == OVF_ADDR) ? wval[NUM_CTRS-1:0] : ovf)
                 | wrap;
            for (int i = 0; i < NUM_CTRS; i++) begin
                if (wen && waddr == EVT_BASE + 12'(i))
                    evt_sel[i] <= wval[ESW-1:0];
            end
        end
    end

    assign ovf_irq = |(ovf & ovf_ie);

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_IDLE;
            htif_pcr_resp_data <= '0;
        end else begin
            state <= state_nxt;
            if (fire) htif_pcr_resp_data <= 64'(host_rd[XLEN-1:0]);
        end
    end

    always_comb begin
        state_nxt           = state;
        htif_pcr_req_ready  = 1'b0;
        htif_pcr_resp_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                htif_pcr_req_ready = ~core_wen;
                if (htif_pcr_req_valid & ~core_wen) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                htif_pcr_resp_valid = 1'b1;
                if (htif_pcr_resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign unused_ok = ^{htif_pcr_req_data, host_rd};

endmodule

// File: tb/tb_vscale_hpm_counter_bank.sv
// Directed self-checking bench for vscale_hpm_counter_bank.
// Snapshot scenario is built when VSCALE_HPM_SNAPSHOT_EN is defined.
module tb_vscale_hpm_counter_bank;

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_READ  = 3'd4;
    localparam logic [2:0] C_WRITE = 3'd5;
    localparam logic [2:0] C_SET   = 3'd6;
    localparam logic [2:0] C_CLEAR = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] addr = '0;
    logic [2:0]  cmd = C_IDLE;
    logic [1:0]  prv = 2'd3;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        hit, illegal_access, ovf_irq;
    logic [7:0]  events = '0;
    logic        req_valid = 1'b0, req_ready, req_rw = 1'b0;
    logic [11:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic        resp_valid, resp_ready = 1'b0;
    logic [63:0] resp_data;

    int compared = 0;
    int mismatched = 0;

    vscale_hpm_counter_bank dut (
        .clk                 (clk),
        .reset               (reset),
        .addr                (addr),
        .cmd                 (cmd),
        .prv                 (prv),
        .wdata               (wdata),
        .rdata               (rdata),
        .hit                 (hit),
        .illegal_access      (illegal_access),
        .events              (events),
        .ovf_irq             (ovf_irq),
        .htif_pcr_req_valid  (req_valid),
        .htif_pcr_req_ready  (req_ready),
        .htif_pcr_req_rw     (req_rw),
        .htif_pcr_req_addr   (req_addr),
        .htif_pcr_req_data   (req_data),
        .htif_pcr_resp_valid (resp_valid),
        .htif_pcr_resp_ready (resp_ready),
        .htif_pcr_resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cmd = C_IDLE; events = '0;
        req_valid = 1'b0; resp_ready = 1'b0; prv = 2'd3;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic csr_op(input logic [2:0] c, input logic [11:0] a,
                          input logic [31:0] d);
        @(negedge clk);
        cmd = c; addr = a; wdata = d;
        @(negedge clk);
        cmd = C_IDLE;
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
        @(negedge clk);
        cmd = C_READ; addr = a;
        #1 d = rdata;
        @(negedge clk);
        cmd = C_IDLE;
    endtask

    task automatic pulse(input int k, input int n);
        @(negedge clk);
        events = 8'(1 << k);
        repeat (n) @(negedge clk);
        events = '0;
    endtask

    task automatic host_xact(input logic rw, input logic [11:0] a,
                             input logic [31:0] d, output logic [63:0] r);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_data = 64'(d);
        n = 0;
        #1;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            compared++; mismatched++;
            $display("FAIL host_req_timeout addr=%h", a);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1 r = resp_data;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        #1;
        compared++;
        if ({req_ready, resp_valid, ovf_irq} !== 3'b100) begin
            mismatched++;
            $display("FAIL reset_flags got=%b exp=100",
                     {req_ready, resp_valid, ovf_irq});
        end
        compared++;
        if (resp_data !== 64'h0) begin
            mismatched++;
            $display("FAIL reset_resp_data got=%h exp=0", resp_data);
        end
        csr_rd(12'h320, v);
        compared++;
        if (v !== 32'hF) begin
            mismatched++;
            $display("FAIL reset_inhibit got=%h exp=f", v);
        end
        csr_rd(12'hB03, v);
        compared++;
        if (v !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_ctr0 got=%h exp=0", v);
        end
    endtask

    task automatic test_count();
        logic [31:0] v;
        csr_op(C_WRITE, 12'h320, 32'h0);
        csr_op(C_WRITE, 12'h323, 32'h2);
        csr_op(C_WRITE, 12'h324, 32'hFF);
        csr_rd(12'h324, v);
        compared++;
        if (v !== 32'hF) begin
            mismatched++;
            $display("FAIL evt_sel_trunc got=%h exp=f", v);
        end
        pulse(2, 5);
        csr_rd(12'hB03, v);
        compared++;
        if (v !== 32'd5) begin
            mismatched++;
            $display("FAIL count_ctr0 got=%h exp=5", v);
        end
        csr_rd(12'hB04, v);
        compared++;
        if (v !== 32'd0) begin
            mismatched++;
            $display("FAIL count_ctr1 got=%h exp=0", v);
        end
        @(negedge clk);
        events = 8'h04; cmd = C_READ; addr = 12'hB03;
        @(negedge clk);
        events = '0;
        #1;
        compared++;
        if (rdata !== 32'd6) begin
            mismatched++;
            $display("FAIL event_next_cycle got=%h exp=6", rdata);
        end
        cmd = C_IDLE;
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        csr_op(C_WRITE, 12'hB83, 32'hFFFFFFFF);
        csr_op(C_WRITE, 12'hB03, 32'hFFFFFFFE);
        csr_op(C_WRITE, 12'h7C1, 32'h1);
        pulse(2, 2);
        csr_rd(12'hB03, v);
        compared++;
        if (v !== 32'h0) begin
            mismatched++;
            $display("FAIL wrap_lo got=%h exp=0", v);
        end
        csr_rd(12'hB83, v);
        compared++;
        if (v !== 32'h0) begin
            mismatched++;
            $display("FAIL wrap_hi got=%h exp=0", v);
        end
        csr_rd(12'h7C0, v);
        compared++;
        if (v !== 32'h1 || ovf_irq !== 1'b1) begin
            mismatched++;
            $display("FAIL ovf_set got=%h irq=%b exp=1 irq=1", v, ovf_irq);
        end
        csr_op(C_WRITE, 12'h7C0, 32'h0);
        #1;
        compared++;
        if (ovf_irq !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_clear_irq got=%b exp=0", ovf_irq);
        end
        csr_op(C_WRITE, 12'hB83, 32'hFFFFFFFF);
        csr_op(C_WRITE, 12'hB03, 32'hFFFFFFFF);
        @(negedge clk);
        cmd = C_WRITE; addr = 12'h7C0; wdata = 32'h0; events = 8'h04;
        @(negedge clk);
        cmd = C_IDLE; events = '0;
        csr_rd(12'h7C0, v);
        compared++;
        if (v !== 32'h1) begin
            mismatched++;
            $display("FAIL ovf_set_wins got=%h exp=1", v);
        end
        csr_rd(12'hB03, v);
        compared++;
        if (v !== 32'h0) begin
            mismatched++;
            $display("FAIL wrap3_lo got=%h exp=0", v);
        end
    endtask

    task automatic test_setclear();
        logic [31:0] v;
        do_reset();
        csr_op(C_SET, 12'h320, 32'h2);
        csr_op(C_CLEAR, 12'h320, 32'h1);
        csr_rd(12'h320, v);
        compared++;
        if (v !== 32'hE) begin
            mismatched++;
            $display("FAIL set_clear_inhibit got=%h exp=e", v);
        end
        @(negedge clk);
        cmd = C_WRITE; addr = 12'hC00; wdata = 32'hC00;
        #1;
        compared++;
        if ({illegal_access, hit} !== 2'b10) begin
            mismatched++;
            $display("FAIL illegal_unmapped got=%b exp=10",
                     {illegal_access, hit});
        end
        @(negedge clk);
        cmd = C_WRITE; addr = 12'h7C1; wdata = 32'hF; prv = 2'd1;
        #1;
        compared++;
        if (illegal_access !== 1'b1) begin
            mismatched++;
            $display("FAIL illegal_priv_write got=%b exp=1", illegal_access);
        end
        @(negedge clk);
        cmd = C_IDLE; prv = 2'd3;
        csr_rd(12'h7C1, v);
        compared++;
        if (v !== 32'h0) begin
            mismatched++;
            $display("FAIL illegal_no_effect got=%h exp=0", v);
        end
        csr_rd(12'h320, v);
        compared++;
        if (v !== 32'hE) begin
            mismatched++;
            $display("FAIL illegal_inhibit_kept got=%h exp=e", v);
        end
    endtask

    task automatic test_host();
        logic [63:0] r;
        logic [31:0] v;
        host_xact(1'b1, 12'hB04, 32'd7, r);
        compared++;
        if (r !== 64'h0) begin
            mismatched++;
            $display("FAIL host_write_prev got=%h exp=0", r);
        end
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'hB04;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        compared++;
        if (resp_data !== 64'd7) begin
            mismatched++;
            $display("FAIL host_read got=%h exp=7", resp_data);
        end
        for (int k = 0; k < 3; k++) begin
            compared++;
            if ({resp_valid, req_ready} !== 2'b10) begin
                mismatched++;
                $display("FAIL host_hold%0d got=%b exp=10", k,
                         {resp_valid, req_ready});
            end
            @(negedge clk);
            #1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        compared++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL host_release got=%b exp=01",
                     {resp_valid, req_ready});
        end
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h7C1;
        cmd = C_WRITE; addr = 12'h7C1; wdata = 32'h1;
        #1;
        compared++;
        if (req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL host_core_prio got=%b exp=0", req_ready);
        end
        @(negedge clk);
        cmd = C_IDLE;
        #1;
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL host_after_core got=%b exp=1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        compared++;
        if (resp_valid !== 1'b1 || resp_data !== 64'h1) begin
            mismatched++;
            $display("FAIL host_sees_core_write got=%b/%h exp=1/1",
                     resp_valid, resp_data);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        prv = 2'd0;
        host_xact(1'b1, 12'h7C1, 32'h0, r);
        prv = 2'd3;
        csr_rd(12'h7C1, v);
        compared++;
        if (v !== 32'h0) begin
            mismatched++;
            $display("FAIL host_no_priv got=%h exp=0", v);
        end
        host_xact(1'b1, 12'hC00, 32'd5, r);
        host_xact(1'b0, 12'hC00, 32'd0, r);
        compared++;
        if (r !== 64'h0) begin
            mismatched++;
            $display("FAIL host_unmapped got=%h exp=0", r);
        end
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'hB04;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        compared++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL host_reset_abandon got=%b exp=01",
                     {resp_valid, req_ready});
        end
    endtask

    task automatic test_priv();
        @(negedge clk);
        prv = 2'd0; cmd = C_READ; addr = 12'h323;
        #1;
        compared++;
        if (illegal_access !== 1'b1) begin
            mismatched++;
            $display("FAIL priv_read got=%b exp=1", illegal_access);
        end
        @(negedge clk);
        prv = 2'd3; addr = 12'h323;
        #1;
        compared++;
        if ({illegal_access, hit} !== 2'b01) begin
            mismatched++;
            $display("FAIL priv_ok got=%b exp=01", {illegal_access, hit});
        end
        @(negedge clk);
        addr = 12'hB07;
        #1;
        compared++;
        if ({hit, rdata} !== 33'h0) begin
            mismatched++;
            $display("FAIL past_last_ctr hit=%b rdata=%h exp=0/0", hit, rdata);
        end
        @(negedge clk);
        cmd = C_IDLE;
    endtask

`ifdef VSCALE_HPM_SNAPSHOT_EN
    task automatic test_snapshot();
        logic [31:0] v;
        do_reset();
        csr_op(C_WRITE, 12'h320, 32'h0);
        csr_op(C_WRITE, 12'h323, 32'h2);
        csr_op(C_WRITE, 12'hB83, 32'h1);
        csr_op(C_WRITE, 12'hB03, 32'hFFFFFFFF);
        @(negedge clk);
        events = 8'h04; cmd = C_READ; addr = 12'hB03;
        @(negedge clk);
        cmd = C_IDLE;
        repeat (2) @(negedge clk);
        cmd = C_READ; addr = 12'hB83;
        #1 v = rdata;
        compared++;
        if (v !== 32'h1) begin
            mismatched++;
            $display("FAIL snapshot_hi got=%h exp=1", v);
        end
        @(negedge clk);
        cmd = C_IDLE; events = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_count();
        test_overflow();
        test_setclear();
        test_host();
        test_priv();
`ifdef VSCALE_HPM_SNAPSHOT_EN
        test_snapshot();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
